// File: rtl/fast_segment_test_if.sv
// fast_segment_test_if: groups the request and result signals of fast_segment_test.
//   master: drives start, buff_input, center_value, threshold; observes the results.
//   slave : the segment-test engine.
//   start         - request a test (sampled only when idle)
//   buff_input    - 16 ring pixels, index order as produced by buffer_loader
//   center_value  - centre pixel
//   threshold     - intensity threshold t
//   busy          - engine is scanning or presenting its result
//   done          - one-cycle pulse when results become valid
//   is_corner     - longest arc reaches the arc-length requirement
//   corner_bright - longest arc is bright (1) or dark (0)
//   max_run       - longest contiguous same-class arc, 0..16
interface fast_segment_test_if;
    logic             start;
    logic [15:0][7:0] buff_input;
    logic [7:0]       center_value;
    logic [7:0]       threshold;
    logic             busy;
    logic             done;
    logic             is_corner;
    logic             corner_bright;
    logic [4:0]       max_run;

    modport master (
        output start, buff_input, center_value, threshold,
        input  busy, done, is_corner, corner_bright, max_run
    );

    modport slave (
        input  start, buff_input, center_value, threshold,
        output busy, done, is_corner, corner_bright, max_run
    );
endinterface

// File: rtl/fast_segment_test.sv
// fast_segment_test: sequential FAST segment test. Latches the 16 ring pixels, the centre
// pixel and the threshold on start, then walks the ring twice (32 cycles) tracking the
// longest contiguous bright and dark arcs, so arcs wrapping across index 15->0 are found.
//   clk   - system clock, rising edge
//   n_rst - asynchronous active-low reset
//   bus   - request/result bundle (slave modport)
// ARC_LEN sets the minimum arc length that qualifies as a corner (legal 9..12).
module fast_segment_test #(
    parameter int unsigned ARC_LEN = 9
) (
    input logic                clk,
    input logic                n_rst,
    fast_segment_test_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    localparam logic [4:0] RunMax = 5'd16;
    localparam logic [4:0] ArcLen = 5'(ARC_LEN);

    state_e           state_q, state_d;
    logic [4:0]       idx_q, idx_d;
    logic [15:0][7:0] pix_q, pix_d;
    logic [7:0]       hi_q, hi_d;
    logic [7:0]       lo_q, lo_d;
    logic [4:0]       run_b_q, run_b_d;
    logic [4:0]       run_d_q, run_d_d;
    logic [4:0]       max_b_q, max_b_d;
    logic [4:0]       max_d_q, max_d_d;
    logic [4:0]       max_run_q, max_run_d;
    logic             corner_q, corner_d;
    logic             bright_q, bright_d;

    logic [8:0]       sum9, diff9;
    logic [7:0]       cur_pix;
    logic             is_b, is_d;
    logic [4:0]       run_b_nxt, run_d_nxt, max_b_nxt, max_d_nxt;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pix_d     = pix_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        run_b_d   = run_b_q;
        run_d_d   = run_d_q;
        max_b_d   = max_b_q;
        max_d_d   = max_d_q;
        max_run_d = max_run_q;
        corner_d  = corner_q;
        bright_d  = bright_q;

        // Bounds at 9 bits so the saturation to 0..255 is exact.
        sum9  = {1'b0, bus.center_value} + {1'b0, bus.threshold};
        diff9 = {1'b0, bus.center_value} - {1'b0, bus.threshold};

        // Index wraps mod 16 so the second lap continues arcs across 15->0.
        cur_pix = pix_q[idx_q[3:0]];
        is_b    = cur_pix > hi_q;
        is_d    = cur_pix < lo_q;

        run_b_nxt = is_b ? ((run_b_q == RunMax) ? RunMax : run_b_q + 5'd1) : 5'd0;
        run_d_nxt = is_d ? ((run_d_q == RunMax) ? RunMax : run_d_q + 5'd1) : 5'd0;
        max_b_nxt = (run_b_nxt > max_b_q) ? run_b_nxt : max_b_q;
        max_d_nxt = (run_d_nxt > max_d_q) ? run_d_nxt : max_d_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StScan;
                    idx_d   = 5'd0;
                    pix_d   = bus.buff_input;
                    hi_d    = sum9[8] ? 8'd255 : sum9[7:0];
                    lo_d    = diff9[8] ? 8'd0 : diff9[7:0];
                    run_b_d = 5'd0;
                    run_d_d = 5'd0;
                    max_b_d = 5'd0;
                    max_d_d = 5'd0;
                end
            end
            StScan: begin
                run_b_d = run_b_nxt;
                run_d_d = run_d_nxt;
                max_b_d = max_b_nxt;
                max_d_d = max_d_nxt;
                idx_d   = idx_q + 5'd1;
                if (idx_q == 5'd31) begin
                    state_d   = StDone;
                    max_run_d = (max_b_nxt >= max_d_nxt) ? max_b_nxt : max_d_nxt;
                    bright_d  = max_b_nxt >= max_d_nxt;
                    corner_d  = ((max_b_nxt >= max_d_nxt) ? max_b_nxt : max_d_nxt) >= ArcLen;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= StIdle;
            idx_q     <= 5'd0;
            pix_q     <= '0;
            hi_q      <= 8'd0;
            lo_q      <= 8'd0;
            run_b_q   <= 5'd0;
            run_d_q   <= 5'd0;
            max_b_q   <= 5'd0;
            max_d_q   <= 5'd0;
            max_run_q <= 5'd0;
            corner_q  <= 1'b0;
            bright_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pix_q     <= pix_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            run_b_q   <= run_b_d;
            run_d_q   <= run_d_d;
            max_b_q   <= max_b_d;
            max_d_q   <= max_d_d;
            max_run_q <= max_run_d;
            corner_q  <= corner_d;
            bright_q  <= bright_d;
        end
    end

    assign bus.busy          = (state_q == StScan) || (state_q == StDone);
    assign bus.done          = (state_q == StDone);
    assign bus.max_run       = max_run_q;
    assign bus.is_corner     = corner_q;
    assign bus.corner_bright = bright_q;

endmodule

// File: tb/tb_fast_segment_test.sv
module tb_fast_segment_test;

    logic clk;
    logic n_rst;
    int   total;
    int   bad;

    fast_segment_test_if bus_if ();

    fast_segment_test #(.ARC_LEN(9)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [15:0][7:0] pix;
        logic [7:0]       c;
        logic [7:0]       t;
        int               run;
        int               corner;
        int               bright;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Longest circular arc per class, found by trying every start position.
    function automatic void model(input logic [15:0][7:0] p, input logic [7:0] c,
                                  input logic [7:0] t, output int run, output int bright,
                                  output int corner);
        int hi, lo, mb, md, lb, ld;
        hi = int'(c) + int'(t);
        if (hi > 255) hi = 255;
        lo = int'(c) - int'(t);
        if (lo < 0) lo = 0;
        mb = 0;
        md = 0;
        for (int s = 0; s < 16; s++) begin
            lb = 0;
            while (lb < 16 && int'(p[(s + lb) % 16]) > hi) lb++;
            ld = 0;
            while (ld < 16 && int'(p[(s + ld) % 16]) < lo) ld++;
            if (lb > mb) mb = lb;
            if (ld > md) md = ld;
        end
        run    = (mb >= md) ? mb : md;
        bright = (mb >= md) ? 1 : 0;
        corner = (run >= 9) ? 1 : 0;
    endfunction

    function automatic logic [15:0][7:0] fill(input logic [7:0] v);
        logic [15:0][7:0] p;
        for (int i = 0; i < 16; i++) p[i] = v;
        return p;
    endfunction

    task automatic chk_result(input string name, input int run, input int corner,
                              input int bright);
        chk({name, ".max_run"}, 32'(bus_if.max_run), run);
        chk({name, ".is_corner"}, 32'(bus_if.is_corner), corner);
        chk({name, ".corner_bright"}, 32'(bus_if.corner_bright), bright);
    endtask

    // Pulse start, measure latency to done, check done width and busy shape, then results.
    task automatic run_test(input string name, input logic [15:0][7:0] p, input logic [7:0] c,
                            input logic [7:0] t, input int run, input int corner,
                            input int bright);
        int n;
        @(negedge clk);
        bus_if.buff_input   = p;
        bus_if.center_value = c;
        bus_if.threshold    = t;
        bus_if.start        = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        chk({name, ".busy_rise"}, 32'(bus_if.busy), 1);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus_if.done) begin
                n = i;
                break;
            end
        end
        chk({name, ".latency"}, n, 32);
        if (n != 0) begin
            chk({name, ".busy_at_done"}, 32'(bus_if.busy), 1);
            chk_result(name, run, corner, bright);
            @(posedge clk);
            #1;
            chk({name, ".done_width"}, 32'(bus_if.done), 0);
            chk({name, ".busy_fall"}, 32'(bus_if.busy), 0);
            chk_result({name, ".hold"}, run, corner, bright);
        end
    endtask

    initial begin
        logic [15:0][7:0] p;
        int run, bright, corner, dones, done_cyc;
        logic [7:0] c, t;

        total = 0;
        bad   = 0;
        bus_if.start        = 1'b0;
        bus_if.buff_input   = '0;
        bus_if.center_value = 8'd0;
        bus_if.threshold    = 8'd0;

        // Hand-derived vectors.
        tbl[0] = '{"all_bright", fill(8'd255), 8'd100, 8'd20, 16, 1, 1};
        for (int i = 0; i < 16; i++) p[i] = (i <= 8) ? 8'd0 : 8'd100;
        tbl[1] = '{"dark_arc", p, 8'd100, 8'd20, 9, 1, 0};
        for (int i = 0; i < 16; i++) p[i] = (i >= 12 || i <= 4) ? 8'd200 : 8'd100;
        tbl[2] = '{"wrap9", p, 8'd100, 8'd20, 9, 1, 1};
        for (int i = 0; i < 16; i++) p[i] = (i <= 7) ? 8'd200 : 8'd100;
        tbl[3] = '{"run8", p, 8'd100, 8'd20, 8, 0, 1};
        tbl[4] = '{"at_hi", fill(8'd120), 8'd100, 8'd20, 0, 0, 1};
        tbl[5] = '{"above_hi", fill(8'd121), 8'd100, 8'd20, 16, 1, 1};
        tbl[6] = '{"hi_sat", fill(8'd255), 8'd250, 8'd20, 0, 0, 1};
        tbl[7] = '{"lo_sat", fill(8'd0), 8'd10, 8'd20, 0, 0, 1};
        for (int i = 0; i < 16; i++) p[i] = (i % 2 == 0) ? 8'd255 : 8'd0;
        tbl[8] = '{"alternate", p, 8'd128, 8'd10, 1, 0, 1};
        tbl[9] = '{"all_dark", fill(8'd0), 8'd100, 8'd20, 16, 1, 0};

        n_rst = 1'b0;
        #23;
        chk("reset.busy", 32'(bus_if.busy), 0);
        chk("reset.done", 32'(bus_if.done), 0);
        chk_result("reset", 0, 0, 0);
        @(negedge clk);
        n_rst = 1'b1;

        foreach (tbl[k]) run_test(tbl[k].name, tbl[k].pix, tbl[k].c, tbl[k].t, tbl[k].run,
                                  tbl[k].corner, tbl[k].bright);

        // Start toggled during SCAN, inputs changed after latch: one done, first data.
        @(negedge clk);
        bus_if.buff_input   = tbl[1].pix;
        bus_if.center_value = 8'd100;
        bus_if.threshold    = 8'd20;
        bus_if.start        = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        dones    = 0;
        done_cyc = 0;
        for (int cyc = 1; cyc <= 70; cyc++) begin
            @(negedge clk);
            if (cyc == 3) begin
                bus_if.buff_input = fill(8'd255);
                bus_if.threshold  = 8'd0;
            end
            bus_if.start = (cyc >= 5 && cyc <= 30) ? cyc[0] : 1'b0;
            @(posedge clk);
            #1;
            if (bus_if.done) begin
                dones++;
                if (done_cyc == 0) done_cyc = cyc;
            end
        end
        chk("toggle.dones", dones, 1);
        chk("toggle.latency", done_cyc, 32);
        chk_result("toggle", 9, 1, 0);

        // Reset while index 10 is being processed: outputs clear, no done follows.
        @(negedge clk);
        bus_if.buff_input = fill(8'd255);
        bus_if.center_value = 8'd100;
        bus_if.threshold    = 8'd20;
        bus_if.start        = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk("abort.busy", 32'(bus_if.busy), 0);
        chk("abort.done", 32'(bus_if.done), 0);
        chk_result("abort", 0, 0, 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        dones = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk);
            #1;
            if (bus_if.done || bus_if.busy) dones++;
        end
        chk("abort.no_done", dones, 0);
        run_test("after_reset", tbl[2].pix, 8'd100, 8'd20, 9, 1, 1);

        // Random rings built from class runs, checked against the arc model.
        for (int r = 0; r < 24; r++) begin
            int cls, hi, lo;
            c = 8'($urandom_range(0, 255));
            t = 8'($urandom_range(0, 60));
            hi = int'(c) + int'(t);
            lo = int'(c) - int'(t);
            cls = $urandom_range(0, 2);
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 3) == 0) cls = $urandom_range(0, 2);
                if (cls == 0 && hi < 255) p[i] = 8'($urandom_range(hi + 1, 255));
                else if (cls == 1 && lo > 0) p[i] = 8'($urandom_range(0, lo - 1));
                else p[i] = 8'($urandom_range(0, 255));
            end
            model(p, c, t, run, bright, corner);
            run_test($sformatf("rand%0d", r), p, c, t, run, corner, bright);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fast_segment_test.md
# fast_segment_test

Sequential FAST segment-test engine that sits directly downstream of `buffer_loader`. It takes the 16 Bresenham-circle pixels and the centre pixel from that block, classifies each ring pixel as bright, dark or similar against a threshold, and walks the ring twice to find the longest contiguous same-class arc, including arcs that wrap across index 15→0. It reports whether the candidate is a corner, the corner polarity and the longest arc length.

## Interface
- `ARC_LEN`, default 9: minimum contiguous arc length for a corner; legal range 9..12.
- `clk` input 1: system clock, rising-edge.
- `n_rst` input 1: asynchronous active-low reset.
- `start` input 1: request a test; sampled only in IDLE.
- `buff_input` input 8 ×[15:0]: ring pixels; index order matches `buff_output` of `buffer_loader`.
- `center_value` input 8: centre pixel.
- `threshold` input 8: intensity threshold t.
- `busy` output 1: high in SCAN and DONE.
- `done` output 1: one-cycle pulse when results become valid.
- `is_corner` output 1: `max_run >= ARC_LEN`.
- `corner_bright` output 1: 1 if the longest run is bright, 0 if dark.
- `max_run` output 5: longest contiguous run, 0..16.

## Operation
- FSM states and transitions:
  - IDLE → SCAN when `start`=1.
  - SCAN → DONE after index 31 is processed.
  - DONE → IDLE unconditionally.
- On the IDLE→SCAN edge the block latches `buff_input[0..15]`, `center_value` and `threshold` into internal registers. Inputs may change afterwards with no effect.
- Bounds, computed at latch time at 9-bit width:
  - hi = min(center + t, 255).
  - lo = max(center − t, 0), i.e. 0 if t > center.
- Classification is strict:
  - bright if p > hi.
  - dark if p < lo.
  - otherwise neither.
- SCAN: a 5-bit index i steps 0..31, one step per cycle, and examines pixel[i mod 16].
  - Bright run counter: +1 if the pixel is bright, else reset to 0. Dark run counter behaves the same for dark pixels.
  - Both counters saturate at 16, so an all-bright ring reports 16, not 32.
  - Running maxima `max_bright` and `max_dark` update each cycle.
- Result:
  - `max_run` = max(`max_bright`, `max_dark`).
  - `corner_bright` = (`max_bright` >= `max_dark`); ties resolve to bright.
  - `is_corner` = (`max_run` >= `ARC_LEN`).
- Result outputs are registers. They update on the SCAN→DONE edge and hold until the next SCAN→DONE edge.
- `start` in SCAN or DONE is ignored. It is not queued.
- Reset, including mid-SCAN, forces IDLE, clears all counters and latches, and sets every output to 0. No `done` is produced for the aborted test.

## Timing
- Reset values: `busy`=0, `done`=0, `is_corner`=0, `corner_bright`=0, `max_run`=0.
- With `start` sampled at edge k:
  - `busy` rises after edge k.
  - Indices 0..31 are processed at edges k+1..k+32.
  - `done` is high for exactly the cycle between edges k+32 and k+33, and results are valid from edge k+32.
  - `busy` falls after edge k+33.
- Fixed latency: 32 cycles from start sample to `done` rising. Throughput is one test per 34 cycles.
- If `start` is held high continuously, the next test is accepted at edge k+34.
- `done` coincides with `busy`=1. Upstream may assert the next `start` while `done`=1; it is taken at the first IDLE edge.

## Test plan
- All-bright ring: centre 100, t=20, all 16 pixels 255, `start` pulsed → `done` exactly 32 cycles after the start edge, `max_run`=16, `is_corner`=1, `corner_bright`=1.
- Dark arc: pixels 0..8 = 0 and 9..15 = 100, centre 100, t=20 → `max_run`=9, `is_corner`=1, `corner_bright`=0.
- Wrap-around arc:
  - Pixels 12..15 and 0..4 = 200, rest 100, centre 100, t=20 → `max_run`=9, `is_corner`=1.
  - Rerun with only pixels 0..7 = 200 → `max_run`=8, `is_corner`=0.
- Threshold edges and saturation, all with t=20:
  - Centre 100, all pixels 120 → `max_run`=0.
  - Centre 100, all pixels 121 → `max_run`=16.
  - Centre 250, all pixels 255 → `max_run`=0, since hi saturates to 255.
  - Centre 10, all pixels 0 → `max_run`=0, since lo saturates to 0.
- Alternating pattern: pixels alternate 255/0, centre 128, t=10 → `max_run`=1, `corner_bright`=1, `is_corner`=0.
- Control:
  - `start` toggled during SCAN → no extra `done`, and results reflect the first latched data.
  - `n_rst` asserted at scan index 10 → all outputs 0 with no `done`.
  - A fresh `start` after reset completes normally, with `done` 32 cycles later.
